// File: rtl/hvac_pkg.sv
// hvac_pkg: shared state encodings, temperature limit and actuator decode for the HVAC controller.
package hvac_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HEAT    = 3'd1,
      COOL    = 3'd2,
      OVERRUN = 3'd3,
      LOCKOUT = 3'd4,
      FAULT   = 3'd5
   } state_e;
   localparam logic [7:0] TEMP_MAX = 8'd99;
   typedef struct packed {
      logic heat;
      logic cool;
      logic fan;
      logic fault;
   } act_t;
   function automatic act_t decode(state_e s);
      return s == HEAT    ? 4'b1010 :
             s == COOL    ? 4'b0110 :
             s == OVERRUN ? 4'b0010 :
             s == FAULT   ? 4'b0001 : 4'b0000;
   endfunction
endpackage

// File: rtl/hvac_tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
   parameter int TICK_DIV = 10000000
) (
   input  logic clk,
   input  logic Reset_n,
   output logic tick
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt_q, cnt_d;
   assign tick = cnt_q == W'(TICK_DIV - 1);
   always_comb cnt_d = tick ? '0 : cnt_q + W'(1);
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/hvac_controller.sv
// hvac_controller: thermostat FSM with minimum run, fan overrun and compressor lockout dwell times.
module hvac_controller
   import hvac_pkg::*;
#(
   parameter int TICK_DIV      = 10000000,
   parameter int HYST          = 1,
   parameter int MIN_ON_TICKS  = 4,
   parameter int OVERRUN_TICKS = 2,
   parameter int MIN_OFF_TICKS = 6
) (
   input  logic       clk,
   input  logic       Reset_n,
   input  logic       Enable,
   input  logic [7:0] CurrentTemp,
   input  logic [7:0] DesiredTemp,
   output logic       Heat,
   output logic       Cool,
   output logic       Fan,
   output logic       Fault,
   output logic [2:0] State
);
   state_e     state_q, state_d;
   logic [7:0] dwell_q, dwell_d;
   logic       tick, cold, hot;
   logic [8:0] cur9, des9, hyst9;
   assign cur9  = {1'b0, CurrentTemp};
   assign des9  = {1'b0, DesiredTemp};
   assign hyst9 = 9'(HYST);
   assign cold  = cur9 + hyst9 < des9;
   assign hot   = cur9 > des9 + hyst9;
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .Reset_n(Reset_n), .tick(tick));
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !Enable ? IDLE : cold ? HEAT : hot ? COOL : IDLE;
         HEAT:    state_d = (!Enable || (dwell_q >= 8'(MIN_ON_TICKS) && cur9 >= des9)) ? OVERRUN : HEAT;
         COOL:    state_d = (!Enable || (dwell_q >= 8'(MIN_ON_TICKS) && cur9 <= des9)) ? OVERRUN : COOL;
         OVERRUN: state_d = dwell_q == 8'(OVERRUN_TICKS) ? LOCKOUT : OVERRUN;
         LOCKOUT: state_d = dwell_q == 8'(MIN_OFF_TICKS) ? IDLE : LOCKOUT;
         default: state_d = LOCKOUT;
      endcase
      if (CurrentTemp > TEMP_MAX) state_d = FAULT;
      // dwell restarts on any state change, otherwise counts ticks and saturates
      dwell_d = state_d != state_q ? '0 : (tick && dwell_q != '1) ? dwell_q + 8'd1 : dwell_q;
   end
   always_ff @(posedge clk or negedge Reset_n)
      if (!Reset_n) begin
         state_q <= LOCKOUT;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
      end
   assign {Heat, Cool, Fan, Fault} = decode(state_q);
   assign State = state_q;
endmodule

// File: tb/tb_hvac_controller.sv
// tb_hvac_controller: directed scenarios plus random stimulus checked against a tick-arithmetic model.
module tb_hvac_controller;
   localparam int TD = 4, HY = 1, MON = 3, OVR = 2, MOFF = 2;
   logic       clk = 0, rst_n = 1, en = 0;
   logic [7:0] cur = 20, des = 25;
   logic       heat, cool, fan, fault;
   logic [2:0] st;
   int tests = 0, fails = 0;
   int k = 0, e = 0, ms = 4;
   always #5 clk = ~clk;
   hvac_controller #(
      .TICK_DIV(TD), .HYST(HY), .MIN_ON_TICKS(MON), .OVERRUN_TICKS(OVR), .MIN_OFF_TICKS(MOFF)
   ) dut (
      .clk(clk), .Reset_n(rst_n), .Enable(en), .CurrentTemp(cur), .DesiredTemp(des),
      .Heat(heat), .Cool(cool), .Fan(fan), .Fault(fault), .State(st)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // states: 0 idle, 1 heat, 2 cool, 3 overrun, 4 lockout, 5 fault
   function automatic int nxt(int s, int dw, bit on, int c, int d);
      if (c > 99) return 5;
      case (s)
         0: return (on && c + HY < d) ? 1 : (on && c > d + HY) ? 2 : 0;
         1: return (!on || (dw >= MON && c >= d)) ? 3 : 1;
         2: return (!on || (dw >= MON && c <= d)) ? 3 : 2;
         3: return dw == OVR ? 4 : 3;
         4: return dw == MOFF ? 0 : 4;
         default: return 4;
      endcase
   endfunction
   task automatic chk_outs();
      chk("state", 32'(st), ms);
      chk("heat", 32'(heat), 32'(ms == 1));
      chk("cool", 32'(cool), 32'(ms == 2));
      chk("fan", 32'(fan), 32'(ms >= 1 && ms <= 3));
      chk("fault", 32'(fault), 32'(ms == 5));
   endtask
   // ticks fire on edges that are multiples of TD after release; dwell = ticks since entry edge
   task automatic cyc();
      int dw, ns;
      dw = k / TD - e / TD;
      ns = nxt(ms, dw, en, int'(cur), int'(des));
      @(posedge clk);
      k++;
      if (ns != ms) begin
         ms = ns;
         e = k;
      end
      #1;
      chk_outs();
   endtask
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask
   task automatic run_until(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && ms != target; i++) cyc();
      chk(tag, 32'(st), target);
   endtask
   task automatic do_reset();
      rst_n = 0;
      #2;
      ms = 4;
      k = 0;
      e = 0;
      chk_outs();
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
   initial begin
      #1;
      do_reset();
      en = 1; cur = 20; des = 25;
      run_until(1, 40, "reach_heat");
      chk("heat_entry_edge", k, 10);
      cycles(4);
      cur = 25;
      run_until(3, 40, "reach_overrun");
      chk("overrun_entry_edge", k, 21);
      run_until(4, 40, "reach_lockout");
      chk("lockout_entry_edge", k, 29);
      run_until(0, 40, "reach_idle");
      chk("idle_entry_edge", k, 37);
      cur = 24;
      cycles(10);
      chk("hyst_hold_idle", 32'(st), 0);
      cur = 27;
      run_until(2, 5, "reach_cool");
      cycles(2);
      des = 40;
      run_until(1, 80, "reversal_heat");
      cycles(2);
      cur = 150;
      cyc();
      chk("fault_state", 32'(st), 5);
      cur = 50;
      cyc();
      chk("fault_exit", 32'(st), 4);
      des = 20;
      run_until(2, 60, "cool_after_fault");
      cycles(3);
      chk("cool_before_rst", 32'(cool), 1);
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            en  = $urandom_range(0, 5) != 0;
            des = 8'($urandom_range(0, 99));
            case ($urandom_range(0, 9))
               0:       cur = 8'($urandom_range(100, 255));
               1, 2, 3: cur = 8'(int'(des) + int'($urandom_range(0, 4)) - 2);
               default: cur = 8'($urandom_range(0, 99));
            endcase
         end
         if ($urandom_range(0, 299) == 0) do_reset();
         else cyc();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hvac_controller.md
HVAC_CONTROLLER -- requirements
Module: hvac_controller

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 10000000, clk cycles per dwell tick.
REQ-002 The module SHALL have parameter HYST, default 1, start-up hysteresis in degrees (0..9).
REQ-003 The module SHALL have parameter MIN_ON_TICKS, default 4, minimum HEAT/COOL run time in ticks.
REQ-004 The module SHALL have parameter OVERRUN_TICKS, default 2, fan-only time after a run, in ticks.
REQ-005 The module SHALL have parameter MIN_OFF_TICKS, default 6, compressor lockout time in ticks.
REQ-006 The module SHALL have port clk, input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-007 The module SHALL have port Reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The module SHALL have port Enable, input, 1 bit, system on/off switch.
REQ-009 The module SHALL have port CurrentTemp, input, 8 bits, unsigned room temperature (valid 0..99) from the thermostat.
REQ-010 The module SHALL have port DesiredTemp, input, 8 bits, unsigned setpoint (0..99) from the thermostat.
REQ-011 The module SHALL have ports Heat, Cool and Fan, outputs, 1 bit each, actuator drives.
REQ-012 The module SHALL have port Fault, output, 1 bit, high for sensor reading out of range.
REQ-013 The module SHALL have port State, output, 3 bits, current FSM state encoding.

Function
REQ-014 The FSM SHALL have states IDLE=0, HEAT=1, COOL=2, OVERRUN=3, LOCKOUT=4 and FAULT=5; outputs SHALL be Moore-decoded from the state register.
REQ-015 Decoded outputs SHALL be: HEAT -> Heat=1,Fan=1; COOL -> Cool=1,Fan=1; OVERRUN -> Fan=1; FAULT -> Fault=1; all other outputs 0.
REQ-016 A free-running prescaler 0..TICK_DIV-1 SHALL emit a one-cycle tick at wrap; a dwell counter SHALL clear on every state change and increment on tick, saturating.
REQ-017 All comparisons SHALL use 9-bit zero-extended arithmetic: "cold" = CurrentTemp + HYST < DesiredTemp; "hot" = CurrentTemp > DesiredTemp + HYST.
REQ-018 IDLE SHALL go to HEAT on the first edge with Enable=1 and cold, to COOL with Enable=1 and hot, and otherwise stay.
REQ-019 HEAT SHALL go to OVERRUN when dwell >= MIN_ON_TICKS and CurrentTemp >= DesiredTemp; COOL likewise with CurrentTemp <= DesiredTemp.
REQ-020 Enable=0 in HEAT or COOL SHALL force OVERRUN on the next edge regardless of dwell.
REQ-021 OVERRUN SHALL go to LOCKOUT when dwell = OVERRUN_TICKS; LOCKOUT SHALL go to IDLE when dwell = MIN_OFF_TICKS.
REQ-022 HEAT SHALL never transition directly to COOL or vice versa; a reversal SHALL always pass through OVERRUN and LOCKOUT.
REQ-023 CurrentTemp > 99 in any state SHALL force FAULT on the next edge, taking priority over all other transitions.
REQ-024 FAULT SHALL go to LOCKOUT on the first edge with CurrentTemp <= 99.
REQ-025 DesiredTemp changes mid-run SHALL only affect exit and entry conditions and SHALL NOT restart the dwell.

Reset
REQ-026 Reset_n=0 SHALL asynchronously force state LOCKOUT and clear the dwell counter and prescaler; Heat, Cool, Fan and Fault SHALL be 0 and State SHALL be 4.
REQ-027 Reset SHALL be released synchronously; the first tick SHALL occur TICK_DIV cycles after release, and a full lockout SHALL elapse before any run.
REQ-028 Reset asserted mid-HEAT or mid-COOL SHALL drop all actuators immediately without an overrun.

Structure
REQ-029 The state encodings, the TEMP_MAX=99 constant and the output decode table SHALL live in a shared package, hvac_pkg.
REQ-030 The prescaler SHALL be a sub-module tick_gen with ports clk, Reset_n and tick, parameterised by TICK_DIV.

Verification
The bench SHALL use TICK_DIV=4, HYST=1, MIN_ON_TICKS=3, OVERRUN_TICKS=2 and MIN_OFF_TICKS=2.
REQ-031 Scenario: reset, then Enable=1, Current=20, Desired=25 -> LOCKOUT for 2 ticks, then HEAT; Heat=Fan=1 one edge after IDLE.
REQ-032 Scenario: in HEAT, Current=25 after 1 tick -> HEAT holds until tick 3, then OVERRUN (Fan only) for 2 ticks, LOCKOUT for 2 ticks, then IDLE.
REQ-033 Scenario: Current=24, Desired=25 (within HYST) in IDLE -> stays IDLE; Current=27 -> COOL.
REQ-034 Scenario: in COOL, Desired raised to 40 (reversal) -> Heat never asserted until COOL, OVERRUN and LOCKOUT complete, then HEAT.
REQ-035 Scenario: Current=150 during HEAT -> FAULT next edge, Heat=Fan=0, Fault=1; Current=50 -> LOCKOUT.
REQ-036 Scenario: Reset_n pulsed low mid-COOL between clock edges -> Cool=Fan=0 immediately and State=4.
